// File: rtl/mem_arbiter_if.sv
// Arbiter bus: per-master request/response lanes plus the shared memory port.
// The slave modport is the arbiter's view; master covers requesters and memory.
interface mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
);
    logic [NUM_MASTERS-1:0]        req;
    logic [NUM_MASTERS-1:0]        we;
    logic [NUM_MASTERS*ADDR_W-1:0] addr;
    logic [NUM_MASTERS*DATA_W-1:0] wdata;
    logic [NUM_MASTERS-1:0]        stall;
    logic [NUM_MASTERS-1:0]        rvalid;
    logic [DATA_W-1:0]             rdata;
    logic                          m_en;
    logic                          m_we;
    logic [ADDR_W-1:0]             m_addr;
    logic [DATA_W-1:0]             m_wdata;
    logic [DATA_W-1:0]             m_rdata;

    modport slave (
        input  req, we, addr, wdata, m_rdata,
        output stall, rvalid, rdata, m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output req, we, addr, wdata, m_rdata,
        input  stall, rvalid, rdata, m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-master memory arbiter; completion strobe 1+WAIT_STATES cycles after the IDLE arbitration cycle.
// Backpressure: every requester is stalled except the granted master in its completion cycle.
module mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int WAIT_STATES = 1,
    parameter bit RR          = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET,
    mem_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    idx_t              g_q, g_d;
    idx_t              lg_q, lg_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;

    idx_t win;
    logic found;
    int   idx;

    // Round-robin scans from the master after the last grant; fixed priority scans from 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (RR) begin
                idx = int'(lg_q) + k;
                if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            end else begin
                idx = k - 1;
            end
            if (!found && bus.req[idx_t'(idx)]) begin
                win   = idx_t'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        lg_d    = lg_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ACCESS;
                    g_d     = win;
                    lg_d    = win;
                    cnt_d   = 4'(WAIT_STATES);
                    we_d    = bus.we[win];
                    addr_d  = bus.addr[win*ADDR_W +: ADDR_W];
                    wdata_d = bus.wdata[win*DATA_W +: DATA_W];
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // done_q marks the completion cycle one cycle ahead so strobes come straight off a flop.
        done_d = (state_d == ACCESS) && (cnt_d == 4'd0);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            g_q     <= '0;
            lg_q    <= idx_t'(NUM_MASTERS - 1);
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            lg_q    <= lg_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    logic active;
    assign active      = (state_q == ACCESS);
    assign bus.m_en    = active;
    assign bus.m_we    = done_q & we_q;
    assign bus.m_addr  = active ? addr_q : '0;
    assign bus.m_wdata = active ? wdata_q : '0;
    assign bus.rdata   = bus.m_rdata;
    assign bus.rvalid  = done_q ? ({{(NUM_MASTERS-1){1'b0}}, 1'b1} << g_q) : '0;
    assign bus.stall   = bus.req & ~bus.rvalid;
endmodule
